// File: rtl/fibo_bcd_ctrl.sv
// fibo_bcd_ctrl: sequencer for the BCD-I/O Fibonacci circuit.
// Takes a 2-digit BCD index, converts it to binary, runs an external
// fibonacci unit through its start/ready/done handshake, and converts the
// binary result back to BCD with a 1-bit-per-cycle double-dabble.
module fibo_bcd_ctrl #(
    parameter int FIB_W   = 21,
    parameter int BCD_DIG = 6,
    parameter int MAX_N   = 30,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             bcd_in,
    output logic                   ready,
    output logic                   done_tick,
    output logic                   err,
    output logic [4*BCD_DIG-1:0]   bcd_out,
    output logic                   fib_start,
    output logic [5:0]             fib_i,
    input  logic                   fib_ready,
    input  logic                   fib_done,
    input  logic [FIB_W-1:0]       fib_val
);

    localparam int BCD_W = 4 * BCD_DIG;
    localparam int SH_W  = BCD_W + FIB_W;
    localparam int CNT_W = $clog2(FIB_W + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, CONV, FSTART, FWAIT, DAB, DONE
    } state_t;

    state_t             state, state_nxt;
    logic [7:0]         bcd_lat;
    logic [SH_W-1:0]    sh;
    logic [SH_W-1:0]    sh_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [TMO_W-1:0]   tmo;
    logic               tmo_hit;
    logic               digit_bad;
    logic [6:0]         n_bin;
    logic               last_bit;

    // One double-dabble step: +3 on every BCD digit >= 5, then shift left.
    function automatic logic [SH_W-1:0] dab_step(input logic [SH_W-1:0] v);
        logic [SH_W-1:0] t;
        t = v;
        for (int d = 0; d < BCD_DIG; d++) begin
            if (t[FIB_W + 4*d +: 4] >= 4'd5)
                t[FIB_W + 4*d +: 4] = t[FIB_W + 4*d +: 4] + 4'd3;
        end
        return {t[SH_W-2:0], 1'b0};
    endfunction

    // Index decode and per-cycle helper signals.
    always_comb begin
        digit_bad = (bcd_lat[7:4] > 4'd9) || (bcd_lat[3:0] > 4'd9);
        n_bin     = {3'b000, bcd_lat[7:4]} * 7'd10 + {3'b000, bcd_lat[3:0]};
        // The start cycle counts as the first waited cycle, so the error
        // fires exactly TIMEOUT cycles after FSTART is entered.
        tmo_hit   = (tmo == TMO_W'(TIMEOUT - 1));
        sh_nxt    = dab_step(sh);
        last_bit  = (bit_cnt == CNT_W'(1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    state_nxt = digit_bad ? DONE : FSTART;
            FSTART: begin
                if (fib_ready)    state_nxt = FWAIT;
                else if (tmo_hit) state_nxt = DONE;
            end
            FWAIT: begin
                if (fib_done)     state_nxt = DAB;
                else if (tmo_hit) state_nxt = DONE;
            end
            DAB:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore-style outputs decoded from state; fib_start also qualified by fib_ready.
    always_comb begin
        ready     = (state == IDLE);
        done_tick = (state == DONE);
        fib_start = (state == FSTART) && fib_ready;
    end

    // Datapath: index latch, fib index, timeout counter, shifter and result.
    // bcd_out/err are loaded on the edge into DONE so they are valid with done_tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_lat <= '0;
            fib_i   <= '0;
            tmo     <= '0;
            bit_cnt <= '0;
            bcd_out <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) bcd_lat <= bcd_in;
                end
                CONV: begin
                    tmo <= '0;
                    if (digit_bad) begin
                        bcd_out <= '0;
                        err     <= 1'b1;
                    end else begin
                        fib_i <= (n_bin > 7'(MAX_N)) ? 6'd31 : n_bin[5:0];
                    end
                end
                FSTART: begin
                    if (fib_ready) begin
                        tmo <= TMO_W'(1);
                    end else if (tmo_hit) begin
                        bcd_out <= '0;
                        err     <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                FWAIT: begin
                    if (fib_done) begin
                        sh      <= {{BCD_W{1'b0}}, fib_val};
                        bit_cnt <= CNT_W'(FIB_W);
                    end else if (tmo_hit) begin
                        bcd_out <= '0;
                        err     <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                DAB: begin
                    sh      <= sh_nxt;
                    bit_cnt <= bit_cnt - 1'b1;
                    if (last_bit) begin
                        bcd_out <= sh_nxt[SH_W-1 -: BCD_W];
                        err     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fibo_bcd_ctrl.sv
// Testbench for fibo_bcd_ctrl with a stub fibonacci unit.
module tb_fibo_bcd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bcd_in;
    logic        ready, done_tick, err, fib_start;
    logic [23:0] bcd_out;
    logic [5:0]  fib_i;
    logic        fib_ready;
    logic        fib_done;
    logic [20:0] fib_val;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int fs_cnt, fs_cyc, dt_cnt, dt_cyc, fd_cnt, fd_cyc;
    int stub_cnt = 0;
    int stub_delay = 3;
    bit stub_en = 1'b1;
    int c0;

    fibo_bcd_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
        .ready(ready), .done_tick(done_tick), .err(err), .bcd_out(bcd_out),
        .fib_start(fib_start), .fib_i(fib_i), .fib_ready(fib_ready),
        .fib_done(fib_done), .fib_val(fib_val)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [20:0] fib_model(input logic [5:0] n);
        int a, b, t;
        if (n > 6'd30) return 21'd999999;
        a = 0; b = 1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b; a = b; b = t;
        end
        return 21'(a);
    endfunction

    // Event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (fib_start) begin fs_cnt++; fs_cyc = cyc; end
        if (done_tick) begin dt_cnt++; dt_cyc = cyc; end
    end

    // Stub fibonacci unit: replies stub_delay cycles after fib_start.
    always @(negedge clk) begin
        fib_done = 1'b0;
        if (fib_start && stub_en) begin
            stub_cnt = stub_delay;
        end else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                fib_done = 1'b1;
                fib_val  = fib_model(fib_i);
                fd_cnt++;
                fd_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        fs_cnt = 0; dt_cnt = 0; fd_cnt = 0;
        fs_cyc = -1; dt_cyc = -1; fd_cyc = -1;
    endtask

    task automatic kick(input logic [7:0] v);
        clr_mon();
        step();
        c0 = cyc;
        bcd_in = v;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (dt_cnt == 0 && k < 400) begin
            step();
            k++;
        end
        if (dt_cnt == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
        step();
    endtask

    task automatic txn(input string tag, input logic [7:0] v, input logic [5:0] exp_i,
                       input logic [23:0] exp_bcd);
        kick(v);
        wait_done(tag);
        check({tag, "_fib_i"}, 32'(fib_i), 32'(exp_i));
        check({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_fs_cyc"}, fs_cyc, c0 + 2);
        check({tag, "_dt_cyc"}, dt_cyc, c0 + 2 + stub_delay + 22);
        check({tag, "_fs_cnt"}, fs_cnt, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bcd_in = 8'h00; fib_ready = 1'b1;
        fib_done = 1'b0; fib_val = '0;
        clr_mon();
        repeat (3) step();
        rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done_tick), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_fib_i", 32'(fib_i), 32'd0);
        check("rst_fstart", 32'(fib_start), 32'd0);

        txn("t1", 8'h10, 6'd10, 24'h000055);
        check("t1_ready_after", 32'(ready), 32'd1);
        txn("t2a", 8'h00, 6'd0, 24'h000000);
        txn("t2b", 8'h30, 6'd30, 24'h832040);
        txn("t3a", 8'h99, 6'd31, 24'h999999);
        txn("t3b", 8'h31, 6'd31, 24'h999999);

        // Reset in the middle of the double-dabble phase.
        kick(8'h10);
        begin
            int k = 0;
            while (fd_cnt == 0 && k < 100) begin step(); k++; end
        end
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6a_ready", 32'(ready), 32'd1);
        check("t6a_done", 32'(done_tick), 32'd0);
        check("t6a_bcd", 32'(bcd_out), 32'd0);
        check("t6a_err", 32'(err), 32'd0);
        check("t6a_fib_i", 32'(fib_i), 32'd0);
        repeat (30) step();
        check("t6a_no_done", dt_cnt, 0);

        // Invalid BCD digit: no fib_start, done two cycles after start.
        kick(8'h1A);
        wait_done("t4");
        check("t4_err", 32'(err), 32'd1);
        check("t4_bcd", 32'(bcd_out), 32'd0);
        check("t4_fs_cnt", fs_cnt, 0);
        check("t4_dt_cyc", dt_cyc, c0 + 2);
        repeat (5) step();
        check("t4_held_err", 32'(err), 32'd1);

        // Fibonacci unit never answers.
        stub_en = 1'b0;
        kick(8'h05);
        wait_done("t5");
        check("t5_err", 32'(err), 32'd1);
        check("t5_bcd", 32'(bcd_out), 32'd0);
        check("t5_dt_cyc", dt_cyc, c0 + 2 + 255);
        check("t5_fs_cnt", fs_cnt, 1);
        stub_en = 1'b1;
        repeat (3) step();

        // Start pulsed while busy is ignored.
        kick(8'h05);
        repeat (6) step();
        bcd_in = 8'h20;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("t6b");
        check("t6b_bcd", 32'(bcd_out), 32'h000005);
        check("t6b_err", 32'(err), 32'd0);
        check("t6b_fs_cnt", fs_cnt, 1);
        repeat (30) step();
        check("t6b_dt_cnt", dt_cnt, 1);

        // fib_ready low for the first 5 FSTART cycles.
        fib_ready = 1'b0;
        kick(8'h07);
        while (cyc < c0 + 7) step();
        check("t6c_no_fs_yet", fs_cnt, 0);
        fib_ready = 1'b1;
        wait_done("t6c");
        check("t6c_fs_cyc", fs_cyc, c0 + 7);
        check("t6c_fs_cnt", fs_cnt, 1);
        check("t6c_bcd", 32'(bcd_out), 32'h000013);
        check("t6c_dt_cyc", dt_cyc, c0 + 7 + stub_delay + 22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
